// File: rtl/kanagawa_reset_pkg.sv
// Shared types and helpers for the reset release sequencer and its pulse stretchers.
package kanagawa_reset_pkg;

   typedef enum logic [1:0] {
      ASSERT  = 2'd0,
      HOLD    = 2'd1,
      STAGGER = 2'd2,
      RUN     = 2'd3
   } reset_seq_state_t;

   function automatic int count_width(input int max);
      return $clog2(max + 1);
   endfunction

endpackage

// File: rtl/reset_pulse_stretcher.sv
// Retriggerable soft-reset pulse generator for one channel.
// A request reloads the counter, so back-to-back requests extend the pulse rather than queue.
module reset_pulse_stretcher
   import kanagawa_reset_pkg::*;
#(
   parameter int PULSE_CYCLES = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic req,
   output logic active
);

   localparam int CW = count_width(PULSE_CYCLES);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (enable && req) begin
         cnt_d = CW'(PULSE_CYCLES);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign active = (cnt_q != '0);

endmodule

// File: rtl/reset_release_sequencer.sv
// Staggered multi-channel reset release with per-channel soft-reset pulses.
// Optional KANAGAWA_RESET_X_MASK_EN: simulation treats X/Z on rst_n as low and on requests as 0.
module reset_release_sequencer
   import kanagawa_reset_pkg::*;
#(
   parameter int NUM_CHANNELS   = 4,
   parameter int HOLD_CYCLES    = 16,
   parameter int STAGGER_CYCLES = 4,
   parameter int PULSE_CYCLES   = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CHANNELS-1:0] chan_reset_req,
   output logic [NUM_CHANNELS-1:0] reset_out,
   output logic                    all_released
);

   localparam int HW = count_width(HOLD_CYCLES);
   localparam int SW = count_width(STAGGER_CYCLES);
   localparam int IW = count_width(NUM_CHANNELS);

   logic                    rst_n_m;
   logic [NUM_CHANNELS-1:0] req_m;

`ifdef KANAGAWA_RESET_X_MASK_EN
   always_comb begin
      rst_n_m = (rst_n === 1'b1);
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         req_m[i] = (chan_reset_req[i] === 1'b1);
      end
   end
`else
   assign rst_n_m = rst_n;
   assign req_m   = chan_reset_req;
`endif

   reset_seq_state_t        state_q, state_d;
   logic [HW-1:0]           hold_cnt_q, hold_cnt_d;
   logic [SW-1:0]           stag_cnt_q, stag_cnt_d;
   logic [IW-1:0]           chan_idx_q, chan_idx_d;
   logic [NUM_CHANNELS-1:0] released_q, released_d;
   logic [NUM_CHANNELS-1:0] pulse_active;

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      stag_cnt_d = stag_cnt_q;
      chan_idx_d = chan_idx_q;
      released_d = released_q;
      case (state_q)
         ASSERT: begin
            state_d    = HOLD;
            hold_cnt_d = HW'(HOLD_CYCLES - 1);
            chan_idx_d = '0;
            released_d = '0;
         end
         HOLD: begin
            if (hold_cnt_q == '0) begin
               released_d[0] = 1'b1;
               if (NUM_CHANNELS == 1) begin
                  state_d = RUN;
               end else begin
                  state_d    = STAGGER;
                  stag_cnt_d = SW'(STAGGER_CYCLES - 1);
                  chan_idx_d = IW'(1);
               end
            end else begin
               hold_cnt_d = hold_cnt_q - 1'b1;
            end
         end
         STAGGER: begin
            if (stag_cnt_q == '0) begin
               for (int i = 0; i < NUM_CHANNELS; i++) begin
                  if (chan_idx_q == IW'(i)) begin
                     released_d[i] = 1'b1;
                  end
               end
               if (chan_idx_q == IW'(NUM_CHANNELS - 1)) begin
                  state_d    = RUN;
                  chan_idx_d = '0;
               end else begin
                  chan_idx_d = chan_idx_q + 1'b1;
                  stag_cnt_d = SW'(STAGGER_CYCLES - 1);
               end
            end else begin
               stag_cnt_d = stag_cnt_q - 1'b1;
            end
         end
         RUN: begin
            state_d = RUN;
         end
         default: begin
            state_d = ASSERT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n_m) begin
         state_q    <= ASSERT;
         hold_cnt_q <= '0;
         stag_cnt_q <= '0;
         chan_idx_q <= '0;
         released_q <= '0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         stag_cnt_q <= stag_cnt_d;
         chan_idx_q <= chan_idx_d;
         released_q <= released_d;
      end
   end

   // A channel only accepts soft resets once the sequencer has released it.
   generate
      for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
         reset_pulse_stretcher #(
            .PULSE_CYCLES(PULSE_CYCLES)
         ) u_stretch (
            .clk    (clk),
            .rst_n  (rst_n_m),
            .enable (released_q[gi]),
            .req    (req_m[gi]),
            .active (pulse_active[gi])
         );
      end
   endgenerate

   assign reset_out    = ~released_q | pulse_active;
   assign all_released = (state_q == RUN) && (pulse_active == '0);

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Directed self-checking bench for reset_release_sequencer (4 channels, hold 16, stagger 4, pulse 8).
module tb_reset_release_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] chan_reset_req;
   logic [3:0] reset_out;
   logic       all_released;

   int total = 0;
   int bad   = 0;

   reset_release_sequencer #(
      .NUM_CHANNELS  (4),
      .HOLD_CYCLES   (16),
      .STAGGER_CYCLES(4),
      .PULSE_CYCLES  (8)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .chan_reset_req(chan_reset_req),
      .reset_out     (reset_out),
      .all_released  (all_released)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      chan_reset_req = 4'h0;
      repeat (5) tick();
      total++;
      if (reset_out !== 4'hF) begin
         bad++;
         $display("FAIL reset_out_in_reset got=%h want=%h", reset_out, 4'hF);
      end
      total++;
      if (all_released !== 1'b0) begin
         bad++;
         $display("FAIL all_released_in_reset got=%b want=0", all_released);
      end
      $display("test_reset: done");
   endtask

   // Release from reset and follow the staggered sequence; req[3] at cycle 18 must be ignored.
   task automatic test_sequence(input int last_cycle, input logic probe_req);
      logic [3:0] exp_out;
      logic       exp_all;
      rst_n = 1'b1;
      for (int c = 0; c <= last_cycle; c++) begin
         chan_reset_req = (probe_req && c == 18) ? 4'b1000 : 4'h0;
         tick();
         chan_reset_req = 4'h0;
         for (int i = 0; i < 4; i++) exp_out[i] = (c >= 16 + 4 * i) ? 1'b0 : 1'b1;
         exp_all = (c >= 28);
         total++;
         if (reset_out !== exp_out) begin
            bad++;
            $display("FAIL seq_reset_out cycle=%0d got=%h want=%h", c, reset_out, exp_out);
         end
         total++;
         if (all_released !== exp_all) begin
            bad++;
            $display("FAIL seq_all_released cycle=%0d got=%b want=%b", c, all_released, exp_all);
         end
      end
      $display("test_sequence: cycles 0..%0d", last_cycle);
   endtask

   task automatic test_glitch();
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         total++;
         if (reset_out !== 4'hF || all_released !== 1'b0) begin
            bad++;
            $display("FAIL glitch_high cycle=%0d got=%h/%b want=f/0", c, reset_out, all_released);
         end
      end
      rst_n = 1'b0;
      repeat (3) begin
         tick();
         total++;
         if (reset_out !== 4'hF || all_released !== 1'b0) begin
            bad++;
            $display("FAIL glitch_low got=%h/%b want=f/0", reset_out, all_released);
         end
      end
      $display("test_glitch: done");
   endtask

   task automatic test_abort();
      test_sequence(21, 1'b0);
      rst_n = 1'b0;
      tick();
      total++;
      if (reset_out !== 4'hF || all_released !== 1'b0) begin
         bad++;
         $display("FAIL abort_reassert got=%h/%b want=f/0", reset_out, all_released);
      end
      repeat (2) tick();
      test_sequence(31, 1'b0);
      $display("test_abort: done");
   endtask

   // Pulse on channel 2; retrigger_at < 0 means a single request.
   task automatic test_pulse(input int retrigger_at, input int expect_len);
      logic [3:0] exp_out;
      for (int k = 0; k < 16; k++) begin
         chan_reset_req = (k == 0 || k == retrigger_at) ? 4'b0100 : 4'h0;
         tick();
         chan_reset_req = 4'h0;
         exp_out = (k < expect_len) ? 4'b0100 : 4'h0;
         total++;
         if (reset_out !== exp_out) begin
            bad++;
            $display("FAIL pulse_reset_out k=%0d got=%h want=%h", k, reset_out, exp_out);
         end
         total++;
         if (all_released !== (k >= expect_len)) begin
            bad++;
            $display("FAIL pulse_all_released k=%0d got=%b want=%b", k, all_released, k >= expect_len);
         end
      end
      $display("test_pulse: retrigger=%0d len=%0d", retrigger_at, expect_len);
   endtask

   task automatic test_simultaneous();
      logic [3:0] exp_out;
      for (int k = 0; k < 10; k++) begin
         chan_reset_req = (k == 0) ? 4'b1011 : 4'h0;
         tick();
         chan_reset_req = 4'h0;
         exp_out = (k < 8) ? 4'b1011 : 4'h0;
         total++;
         if (reset_out !== exp_out) begin
            bad++;
            $display("FAIL multi_reset_out k=%0d got=%h want=%h", k, reset_out, exp_out);
         end
      end
      $display("test_simultaneous: done");
   endtask

   task automatic test_req_with_reset();
      rst_n = 1'b0;
      chan_reset_req = 4'hF;
      tick();
      chan_reset_req = 4'h0;
      total++;
      if (reset_out !== 4'hF || all_released !== 1'b0) begin
         bad++;
         $display("FAIL req_with_reset got=%h/%b want=f/0", reset_out, all_released);
      end
      repeat (2) tick();
      test_sequence(28, 1'b0);
      $display("test_req_with_reset: done");
   endtask

   initial begin
      rst_n = 1'b0;
      chan_reset_req = 4'h0;
      test_reset();
      test_sequence(31, 1'b1);
      test_glitch();
      test_abort();
      test_pulse(-1, 8);
      test_pulse(5, 13);
      test_simultaneous();
      test_req_with_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
